// File: rtl/vga_bounce_ctrlmod.sv
// Pixel-content generator for the VGA output stage: eight vertical colour
// bars with a bouncing square box drawn on top. The box position and colour
// advance once per frame (on iFrame), so a visible frame never tears.
// Output latency is one clock from iEn/iX/iY to oEn/oData.
module vga_bounce_ctrlmod #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned BOX_SIZE    = 32,
  parameter int unsigned STEP        = 4,
  parameter int unsigned COLOR_SHIFT = 6
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        iEn,
  input  logic [10:0] iX,
  input  logic [9:0]  iY,
  input  logic        iFrame,
  output logic        oEn,
  output logic [15:0] oData
);

  // Bar width in pixels; the bar index is found by comparing against
  // multiples of this, so no divider is built.
  localparam int unsigned BAR_W = H_ACTIVE / 8;

  // Position arithmetic carries one guard bit above the port width so that
  // pos+STEP cannot wrap and pos-STEP is only taken when it cannot underflow.
  localparam logic [11:0] X_MAX  = 12'(H_ACTIVE - BOX_SIZE);
  localparam logic [11:0] X_STEP = 12'(STEP);
  localparam logic [11:0] X_BOX  = 12'(BOX_SIZE);
  localparam logic [10:0] Y_MAX  = 11'(V_ACTIVE - BOX_SIZE);
  localparam logic [10:0] Y_STEP = 11'(STEP);
  localparam logic [10:0] Y_BOX  = 11'(BOX_SIZE);

  // Direction of travel on one axis.
  typedef enum logic {
    DIR_INC = 1'b0,
    DIR_DEC = 1'b1
  } dir_e;

  // Box state.
  dir_e        dx_q, dx_d;
  dir_e        dy_q, dy_d;
  logic [10:0] bx_q, bx_d;
  logic [9:0]  by_q, by_d;
  logic [15:0] frame_q, frame_d;

  // Output pipeline registers.
  logic        en_q;
  logic [15:0] data_q;
  logic [15:0] data_d;

  // Pixel-path intermediates.
  logic [11:0] x_sum;
  logic [10:0] y_sum;
  logic [11:0] pix_x;
  logic [10:0] pix_y;
  logic        hit_x;
  logic        hit_y;
  logic [2:0]  bar_idx;
  logic [15:0] bar_col;
  logic [1:0]  box_idx;
  logic [15:0] box_col;

  // ------------------------------------------------------------------
  // Box state registers: position, direction and frame counter.
  // ------------------------------------------------------------------
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      bx_q    <= '0;
      by_q    <= '0;
      dx_q    <= DIR_INC;
      dy_q    <= DIR_INC;
      frame_q <= '0;
    end else begin
      bx_q    <= bx_d;
      by_q    <= by_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      frame_q <= frame_d;
    end
  end

  // Horizontal bounce: step toward the active edge, clamp and reverse on hit.
  always_comb begin
    x_sum = {1'b0, bx_q} + X_STEP;
    bx_d  = bx_q;
    dx_d  = dx_q;
    if (iFrame) begin
      unique case (dx_q)
        DIR_INC: begin
          if (x_sum >= X_MAX) begin
            bx_d = X_MAX[10:0];
            dx_d = DIR_DEC;
          end else begin
            bx_d = x_sum[10:0];
          end
        end
        DIR_DEC: begin
          if ({1'b0, bx_q} <= X_STEP) begin
            bx_d = '0;
            dx_d = DIR_INC;
          end else begin
            bx_d = bx_q - X_STEP[10:0];
          end
        end
      endcase
    end
  end

  // Vertical bounce: same rules as the horizontal axis with the line limit.
  always_comb begin
    y_sum = {1'b0, by_q} + Y_STEP;
    by_d  = by_q;
    dy_d  = dy_q;
    if (iFrame) begin
      unique case (dy_q)
        DIR_INC: begin
          if (y_sum >= Y_MAX) begin
            by_d = Y_MAX[9:0];
            dy_d = DIR_DEC;
          end else begin
            by_d = y_sum[9:0];
          end
        end
        DIR_DEC: begin
          if ({1'b0, by_q} <= Y_STEP) begin
            by_d = '0;
            dy_d = DIR_INC;
          end else begin
            by_d = by_q - Y_STEP[9:0];
          end
        end
      endcase
    end
  end

  // Frame counter advances on every frame pulse and wraps naturally.
  always_comb begin
    frame_d = frame_q;
    if (iFrame) begin
      frame_d = frame_q + 16'd1;
    end
  end

  // ------------------------------------------------------------------
  // Pixel path (uses the pre-update box state on a frame-pulse cycle).
  // ------------------------------------------------------------------

  // Bar index by a compare chain against bar boundaries.
  always_comb begin
    bar_idx = '0;
    for (int unsigned i = 1; i < 8; i++) begin
      if ({1'b0, iX} >= 12'(i * BAR_W)) begin
        bar_idx = 3'(i);
      end
    end
  end

  // Bar colour lookup.
  always_comb begin
    bar_col = '0;
    unique case (bar_idx)
      3'd0: bar_col = 16'hFFFF;
      3'd1: bar_col = 16'hFFE0;
      3'd2: bar_col = 16'h07FF;
      3'd3: bar_col = 16'h07E0;
      3'd4: bar_col = 16'hF81F;
      3'd5: bar_col = 16'hF800;
      3'd6: bar_col = 16'h001F;
      3'd7: bar_col = 16'h0000;
    endcase
  end

  // Box colour lookup from two bits of the frame counter.
  always_comb begin
    box_idx = frame_q[COLOR_SHIFT+1:COLOR_SHIFT];
    box_col = '0;
    unique case (box_idx)
      2'd0: box_col = 16'hF800;
      2'd1: box_col = 16'h07E0;
      2'd2: box_col = 16'h001F;
      2'd3: box_col = 16'hFFFF;
    endcase
  end

  // Box hit test, inclusive at the box origin and exclusive at origin+size.
  always_comb begin
    pix_x = {1'b0, iX};
    pix_y = {1'b0, iY};
    hit_x = (pix_x >= {1'b0, bx_q}) && (pix_x < ({1'b0, bx_q} + X_BOX));
    hit_y = (pix_y >= {1'b0, by_q}) && (pix_y < ({1'b0, by_q} + Y_BOX));
  end

  // Final pixel select: blank outside the active area, box over bars.
  always_comb begin
    data_d = '0;
    if (iEn) begin
      data_d = (hit_x && hit_y) ? box_col : bar_col;
    end
  end

  // Output registers; reset clears the outputs immediately.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      en_q   <= 1'b0;
      data_q <= '0;
    end else begin
      en_q   <= iEn;
      data_q <= data_d;
    end
  end

  assign oEn   = en_q;
  assign oData = data_q;

endmodule
